// File: rtl/axis_word_to_byte_tx_if.sv
// AXI-stream bundle (tvalid/tready/tdata/tkeep/tlast) shared by the word side and the byte side.
interface axis_word_to_byte_tx_if #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) ();
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_word_to_byte_tx.sv
// Buffers 32-bit response words and serialises them LSB byte first onto an 8-bit stream,
// folding a trailing empty tlast word into the m_tlast of the preceding byte.
module axis_word_to_byte_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  axis_word_to_byte_tx_if.slave  s_axis,
  axis_word_to_byte_tx_if.master m_axis,
  output logic [LVL_W-1:0]       fifo_level,
  output logic [CNT_W-1:0]       pkt_count,
  output logic [CNT_W-1:0]       drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_NEXT} state_t;

  function automatic logic [2:0] nbytes(input logic [3:0] keep);
    if (keep[3])      return 3'd4;
    else if (keep[2]) return 3'd3;
    else if (keep[1]) return 3'd2;
    else if (keep[0]) return 3'd1;
    else              return 3'd0;
  endfunction

  logic [36:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] mem_cnt_q;
  logic             head_vld_q;
  logic [36:0]      head_q;

  state_t           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic [2:0]       n_q, n_d, idx_q, idx_d;
  logic             last_q, last_d, sent_q, sent_d;
  logic [CNT_W-1:0] pkt_q, drop_q;

  logic       wr_en, head_pop, head_load, pkt_inc, drop_inc, m_valid, m_last, final_byte;
  logic [1:0] rel;
  logic [2:0] head_n;
  logic       head_empty_last;

  assign head_n          = nbytes(head_q[35:32]);
  assign head_empty_last = (head_q[35:32] == 4'b0000) && head_q[36];
  assign final_byte      = (idx_q == n_q - 3'd1);

  // Level includes the lookahead head word and the word being shifted out.
  assign fifo_level = mem_cnt_q + LVL_W'(head_vld_q) + LVL_W'(state_q != IDLE);
  assign s_axis.tready = rstn & ((fifo_level < LVL_W'(FIFO_DEPTH)) | (rel != 2'd0));
  assign wr_en         = s_axis.tvalid & s_axis.tready;
  assign head_load     = (mem_cnt_q != '0) && (!head_vld_q || head_pop);

  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = word_q[7:0];
  assign m_axis.tlast  = m_last;
  assign m_axis.tkeep  = '1;
  assign pkt_count     = pkt_q;
  assign drop_count    = drop_q;

  // Storage and registered read are left unreset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    if (head_load) head_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      head_vld_q <= 1'b0;
      state_q    <= IDLE;
      word_q     <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      sent_q     <= 1'b0;
      pkt_q      <= '0;
      drop_q     <= '0;
    end else begin
      if (wr_en)     wr_ptr_q <= wr_ptr_q + 1'b1;
      if (head_load) rd_ptr_q <= rd_ptr_q + 1'b1;
      mem_cnt_q  <= mem_cnt_q + LVL_W'(wr_en) - LVL_W'(head_load);
      head_vld_q <= head_load | (head_vld_q & ~head_pop);
      state_q    <= state_d;
      word_q     <= word_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      sent_q     <= sent_d;
      pkt_q      <= pkt_q + CNT_W'(pkt_inc);
      drop_q     <= drop_q + CNT_W'(drop_inc);
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    n_d      = n_q;
    idx_d    = idx_q;
    last_d   = last_q;
    sent_d   = sent_q;
    head_pop = 1'b0;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    rel      = 2'd0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (head_vld_q) begin
          head_pop = 1'b1;
          if (head_n == 3'd0) begin
            rel = 2'd1;
            if (head_q[36] && !sent_q) drop_inc = 1'b1;
            if (head_q[36]) sent_d = 1'b0;
          end else begin
            word_d  = head_q[31:0];
            n_d     = head_n;
            last_d  = head_q[36];
            idx_d   = 3'd0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (!final_byte) begin
          m_valid = 1'b1;
        end else if (last_q) begin
          m_valid = 1'b1;
          m_last  = 1'b1;
        end else if (head_vld_q) begin
          m_valid = 1'b1;
          m_last  = head_empty_last;
        end else begin
          state_d = WAIT_NEXT;
        end
        if (m_valid && m_axis.tready) begin
          word_d = word_q >> 8;
          idx_d  = idx_q + 3'd1;
          sent_d = 1'b1;
          if (final_byte) begin
            rel     = 2'd1;
            state_d = IDLE;
            if (m_last) begin
              pkt_inc = 1'b1;
              sent_d  = 1'b0;
            end
            if (!last_q && m_last) begin
              // Trailing empty tlast word retires together with this byte.
              head_pop = 1'b1;
              rel      = 2'd2;
            end else if (head_vld_q && head_n != 3'd0) begin
              head_pop = 1'b1;
              word_d   = head_q[31:0];
              n_d      = head_n;
              last_d   = head_q[36];
              idx_d    = 3'd0;
              state_d  = SHIFT;
            end
          end
        end
      end
      WAIT_NEXT: begin
        if (head_vld_q) state_d = SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axis_word_to_byte_tx.sv
// Randomised and directed checks of axis_word_to_byte_tx against a packet-level byte model.
module tb_axis_word_to_byte_tx;
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} word_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  fifo_level;
  logic [15:0] pkt_count, drop_count;

  axis_word_to_byte_tx_if #(.DATA_W(32), .KEEP_W(4)) s_if ();
  axis_word_to_byte_tx_if #(.DATA_W(8),  .KEEP_W(1)) m_if ();

  axis_word_to_byte_tx #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .s_axis(s_if), .m_axis(m_if),
    .fifo_level(fifo_level), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errs = 0;
  word_t      src_q[$];
  logic [7:0] cur_q[$];
  logic [8:0] exp_q[$], obs_q[$];
  int exp_pkts = 0, exp_drops = 0, n_acc = 0, first_hs = -1, last_hs = -1;
  logic [3:0] keeps [8] = '{4'hF, 4'h7, 4'h3, 4'h1, 4'hF, 4'h5, 4'hC, 4'hF};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    word_t w;
    w.d = d; w.k = k; w.l = l;
    src_q.push_back(w);
  endtask

  // Packet model: a word carries bytes up to its highest keep bit; a packet's last byte
  // carries tlast, and a packet with no bytes at all counts as dropped.
  task automatic model_word(input word_t w);
    int n = 0;
    for (int i = 0; i < 4; i++) if (w.k[i]) n = i + 1;
    for (int b = 0; b < n; b++) cur_q.push_back(w.d[8*b +: 8]);
    if (w.l) begin
      if (cur_q.size() == 0) exp_drops++;
      else begin
        for (int j = 0; j < cur_q.size(); j++) exp_q.push_back({j == cur_q.size() - 1, cur_q[j]});
        exp_pkts++;
      end
      cur_q.delete();
    end
  endtask

  task automatic reset_model();
    src_q.delete(); cur_q.delete(); exp_q.delete(); obs_q.delete();
    exp_pkts = 0; exp_drops = 0; n_acc = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rstn = 1'b0; s_if.tvalid = 1'b0; m_if.tready = 1'b0;
    #1;
    check({tag, "_rst_mvalid"}, m_if.tvalid, 1'b0);
    check({tag, "_rst_tdata"},  m_if.tdata, 8'h00);
    check({tag, "_rst_tlast"},  m_if.tlast, 1'b0);
    check({tag, "_rst_level"},  fifo_level, 5'd0);
    check({tag, "_rst_cnts"},   {pkt_count, drop_count}, 32'h0);
    check({tag, "_rst_sready"}, s_if.tready, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    reset_model();
  endtask

  task automatic run(input string tag, input int max_cyc, input int rdy_pct, input int vld_pct,
                     input bit alt, input bit drain, input int stop_bytes);
    bit s_hold = 0, pv = 0, pr = 0, done = 0;
    logic [8:0] pd = '0;
    int idle = 0;
    first_hs = -1; last_hs = -1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      if (!s_hold) s_if.tvalid = (src_q.size() != 0) && ($urandom_range(99) < vld_pct);
      if (s_if.tvalid) begin
        s_if.tdata = src_q[0].d; s_if.tkeep = src_q[0].k; s_if.tlast = src_q[0].l;
      end
      m_if.tready = alt ? (cyc % 2 == 0) : ($urandom_range(99) < rdy_pct);
      #4;
      if (pv && !pr) begin
        check({tag, "_stall_valid"}, m_if.tvalid, 1'b1);
        check({tag, "_stall_data"}, {m_if.tlast, m_if.tdata}, pd);
      end
      pv = m_if.tvalid; pr = m_if.tready; pd = {m_if.tlast, m_if.tdata};
      if (s_if.tvalid && s_if.tready) begin
        model_word(src_q.pop_front());
        n_acc++;
        s_hold = 0;
      end else s_hold = s_if.tvalid;
      if (m_if.tvalid && m_if.tready) begin
        obs_q.push_back(pd);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (stop_bytes > 0 && obs_q.size() >= stop_bytes) begin done = 1; break; end
      if (drain && src_q.size() == 0 && !s_hold && cur_q.size() == 0 && obs_q.size() == exp_q.size())
        idle++;
      else idle = 0;
      if (drain && idle >= 8) begin done = 1; break; end
    end
    if (drain || stop_bytes > 0) check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic compare_phase(input string tag);
    int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    check({tag, "_nbytes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", tag, i), obs_q[i], exp_q[i]);
    check({tag, "_pkt"},   pkt_count, exp_pkts[15:0]);
    check({tag, "_drop"},  drop_count, exp_drops[15:0]);
    check({tag, "_level"}, fifo_level, 5'd0);
    $display("phase %s: %0d bytes, pkt=%0d drop=%0d", tag, obs_q.size(), pkt_count, drop_count);
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic gen_pkt(input int nw, input bit allow_empty);
    for (int w = 0; w < nw; w++) begin
      logic [3:0] k = keeps[$urandom_range(7)];
      if (w == nw - 1 && allow_empty && $urandom_range(3) == 0) k = 4'h0;
      push_word($urandom, k, w == nw - 1);
    end
  endtask

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; m_if.tready = 1'b0;

    // 1: full word followed by an empty tlast word
    do_reset("t1");
    push_word(32'h44332211, 4'hF, 1'b0);
    push_word(32'h0, 4'h0, 1'b1);
    run("t1", 200, 100, 100, 0, 1, 0);
    check("t1_lastbyte", obs_q[3], 9'h144);
    compare_phase("t1");

    // 2: single-byte packet, first-byte latency
    do_reset("t2");
    @(negedge clk);
    s_if.tvalid = 1'b1; s_if.tdata = 32'h000000AB; s_if.tkeep = 4'h1; s_if.tlast = 1'b1;
    m_if.tready = 1'b1;
    #4 check("t2_sready", s_if.tready, 1'b1);
    @(posedge clk); #1 s_if.tvalid = 1'b0;
    @(posedge clk); #1 check("t2_lat1", m_if.tvalid, 1'b0);
    @(posedge clk); #1 check("t2_lat2", {m_if.tvalid, m_if.tlast, m_if.tdata}, {2'b11, 8'hAB});
    @(posedge clk); #1 check("t2_pkt", pkt_count, 16'd1);
    check("t2_idle", m_if.tvalid, 1'b0);

    // 3: 8-byte packet with alternating m_tready
    do_reset("t3");
    push_word(32'h04030201, 4'hF, 1'b0);
    push_word(32'h08070605, 4'hF, 1'b1);
    run("t3", 200, 0, 100, 1, 1, 0);
    compare_phase("t3");

    // 4: fill the FIFO with the byte side stalled, then drain
    do_reset("t4");
    for (int i = 0; i < 17; i++) push_word($urandom, 4'hF, i == 15 || i == 16);
    run("t4fill", 60, 0, 100, 0, 0, 0);
    check("t4_acc", n_acc, 16);
    check("t4_sready", s_if.tready, 1'b0);
    check("t4_level", fifo_level, 5'd16);
    @(negedge clk); s_if.tvalid = 1'b0; src_q.delete();
    run("t4drain", 400, 100, 100, 0, 1, 0);
    check("t4_bytes", obs_q.size(), 64);
    compare_phase("t4");

    // 5: lone empty tlast word is dropped
    do_reset("t5");
    push_word(32'hDEADBEEF, 4'h0, 1'b1);
    run("t5", 100, 100, 100, 0, 1, 0);
    compare_phase("t5");

    // 6: reset in the middle of a packet
    do_reset("t6");
    push_word(32'h04030201, 4'hF, 1'b1);
    run("t6a", 200, 100, 100, 0, 1, 0);
    compare_phase("t6a");
    push_word(32'h44332211, 4'hF, 1'b1);
    run("t6b", 200, 100, 100, 0, 0, 2);
    @(posedge clk); #2;
    rstn = 1'b0; s_if.tvalid = 1'b0;
    #1;
    check("t6_mvalid", m_if.tvalid, 1'b0);
    check("t6_level", fifo_level, 5'd0);
    check("t6_cnts", {pkt_count, drop_count}, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    reset_model();
    push_word(32'hCAFEF00D, 4'h7, 1'b1);
    run("t6c", 200, 100, 100, 0, 1, 0);
    compare_phase("t6c");

    // Randomised traffic with random back-pressure on both sides
    do_reset("rnd");
    for (int p = 0; p < 60; p++) gen_pkt($urandom_range(1, 5), 1'b1);
    run("rnd1", 20000, 60, 70, 0, 1, 0);
    compare_phase("rnd1");
    for (int p = 0; p < 40; p++) gen_pkt($urandom_range(1, 4), 1'b1);
    run("rnd2", 20000, 90, 30, 0, 1, 0);
    compare_phase("rnd2");

    // Sustained 1 byte/clk with full words and no stalls
    for (int p = 0; p < 10; p++)
      for (int w = 0; w < 3; w++) push_word($urandom, 4'hF, w == 2);
    run("tput", 2000, 100, 100, 0, 1, 0);
    check("tput_cycles", last_hs - first_hs + 1, 120);
    compare_phase("tput");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
